branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//   D-stage branch sequencer wrapped around the comparator flags (is0/e0/g0/l0/new).
//   Stalls a branch until its forwarded operands are final, then resolves it. Drives
//   next-PC select and target, and nullifies the delay slot of a not-taken likely branch.
//   Also keeps branch/taken/stall performance counters.
// PARAMETERS
//   MAX_WAIT  3   max legal consecutive operand-wait cycles before wait_err sets
//   CNT_W     32  width of each performance counter
// PORTS
//   clk        in   1      sole clock, rising edge
//   reset      in   1      synchronous, active-low; sampled on rising clk edge
//   ext_stall  in   1      pipeline freeze from elsewhere (MDU busy, etc.)
//   d_valid    in   1      D-stage instruction valid
//   br_type    in   3      0 none,1 beq,2 bne,3 blez,4 bgtz,5 bltz,6 bgez,7 brtz (v2==0)
//   br_likely  in   1      branch-likely variant; ignored when br_type==0
//   opnd_ready in   1      forwarded rs/rt values presented to comparator are final
//   cmp_is0, cmp_e0, cmp_g0, cmp_l0, cmp_new  in 1 each  comparator flags
//   d_pc       in   32     PC of the D-stage branch
//   d_imm16    in   16     branch offset, in words
//   br_stall   out  1      freeze F/D this cycle (comb)
//   npc_sel    out  1      1: take br_target as next PC (comb)
//   br_target  out  32     d_pc + 4 + (sext(d_imm16) << 2), mod 2^32 (comb)
//   flush_ds   out  1      registered; turn the delay-slot instruction now in D into a bubble
//   wait_err   out  1      sticky: a wait exceeded MAX_WAIT
//   cnt_br, cnt_taken, cnt_stall  out CNT_W  resolved branches / taken / stall cycles
// BEHAVIOUR
//   - Reset (reset==0 at an edge): state=IDLE; flush_ds=0; wait_err=0; counters=0;
//     wait counter=0. Comb outputs then follow the IDLE rules.
//   - cond: 1 is0; 2 !is0; 3 e0|l0; 4 g0; 5 l0; 6 !l0; 7 new.
//   - is_br = d_valid & (br_type!=0).
//   - States:
//     - IDLE/WAIT, no ext_stall, is_br:
//       - !opnd_ready: br_stall=1, npc_sel=0; next state WAIT; wait count +1.
//       - opnd_ready: br_stall=0; npc_sel=cond (zero added latency); next state IDLE.
//         If br_likely & !cond, next state NULL.
//     - NULL: flush_ds=1 for exactly this cycle. The decoded D instruction is ignored:
//       no stall, npc_sel=0, no count. Next state IDLE.
//     - flush_ds is a registered output: flush_ds==1 exactly when state==NULL.
//   - ext_stall=1: state, wait count and counters all hold; npc_sel=0; br_stall still
//     computed; flush_ds keeps its value until the freeze releases.
//   - Wait counter:
//     - Clears on resolution or when is_br drops.
//     - WAIT with is_br dropped (kill from a flush) returns to IDLE without counting.
//     - If it reaches MAX_WAIT+1, wait_err sets; wait_err clears only on reset.
//   - Counters (increments in a non-ext_stall cycle; wrap at 2^CNT_W):
//     - cnt_br: +1 per resolution.
//     - cnt_taken: +1 per taken resolution.
//     - cnt_stall: +1 per cycle with br_stall=1.
//   - br_type==0 or d_valid==0: all comb outputs 0 (except br_target, which is don't-care).
//   - Reset mid-WAIT or in NULL: return to IDLE; a pending nullify is dropped.
// TESTING
//   1. beq, opnd_ready=1, is0=1, d_pc=0x3000, imm=0x0004 -> same cycle npc_sel=1,
//      br_target=0x3014, cnt_br=cnt_taken=1.
//   2. bgtz, opnd_ready low 2 cycles then high, g0=1 -> br_stall=1,1,0; npc_sel on 3rd;
//      cnt_stall=2; wait_err=0.
//   3. beq likely, is0=0 -> npc_sel=0; next cycle flush_ds=1 for one cycle; cnt_taken unchanged.
//   4. opnd_ready held low 5 cycles, MAX_WAIT=3 -> wait_err=1 on 4th wait; stays 1 until reset=0.
//   5. ext_stall=1 during a resolvable bne -> npc_sel=0, counters frozen; resolves after release.
//   6. reset=0 in NULL, and imm=0x8000 at d_pc=0x0 -> flush_ds=0 after reset;
//      br_target=0xFFFE0004 (wraps).

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   D-stage branch sequencer sitting on top of the operand comparator flags.
//   A branch is held in D (br_stall) until its forwarded operands are final.
//   It is then resolved in the same cycle: next-PC select plus branch target.
//   When a branch-likely is not taken, the following cycle nullifies the delay
//   slot through flush_ds. The block also keeps branch, taken and stall
//   performance counters, and a sticky error for over-long operand waits.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-low reset
//   i_ext_stall    pipeline freeze from elsewhere; holds all state
//   i_d_valid      D-stage instruction valid
//   i_br_type      0 none,1 beq,2 bne,3 blez,4 bgtz,5 bltz,6 bgez,7 brtz
//   i_br_likely    branch-likely variant
//   i_opnd_ready   comparator operands are final
//   i_cmp_*        comparator flags (is0/e0/g0/l0/new)
//   i_d_pc         PC of the D-stage branch
//   i_d_imm16      branch word offset
//   o_br_stall     freeze F/D this cycle (comb)
//   o_npc_sel      take o_br_target as next PC (comb)
//   o_br_target    d_pc + 4 + sext(imm) << 2 (comb)
//   o_flush_ds     registered; bubble the delay-slot instruction now in D
//   o_wait_err     sticky: an operand wait exceeded MAX_WAIT cycles
//   o_cnt_br/o_cnt_taken/o_cnt_stall  performance counters
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ext_stall,
    input  logic             i_d_valid,
    input  logic [2:0]       i_br_type,
    input  logic             i_br_likely,
    input  logic             i_opnd_ready,
    input  logic             i_cmp_is0,
    input  logic             i_cmp_e0,
    input  logic             i_cmp_g0,
    input  logic             i_cmp_l0,
    input  logic             i_cmp_new,
    input  logic [31:0]      i_d_pc,
    input  logic [15:0]      i_d_imm16,
    output logic             o_br_stall,
    output logic             o_npc_sel,
    output logic [31:0]      o_br_target,
    output logic             o_flush_ds,
    output logic             o_wait_err,
    output logic [CNT_W-1:0] o_cnt_br,
    output logic [CNT_W-1:0] o_cnt_taken,
    output logic [CNT_W-1:0] o_cnt_stall
);

    // Wait counter only needs to reach MAX_WAIT+1; it saturates there.
    localparam int WC_W = $clog2(MAX_WAIT + 2);
    localparam logic [WC_W-1:0] WC_LIM = WC_W'(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_NULL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_cnt_next;
    logic              r_flush_ds;
    logic              r_wait_err;
    logic [CNT_W-1:0]  r_cnt_br;
    logic [CNT_W-1:0]  r_cnt_taken;
    logic [CNT_W-1:0]  r_cnt_stall;

    logic              w_is_br;
    logic              w_cond;
    logic              w_stall;
    logic              w_npc_sel;
    logic              w_resolve;
    logic              w_taken;
    logic              w_err_set;
    logic [31:0]       w_offset;

    assign w_is_br  = i_d_valid & (i_br_type != 3'd0);

    // Branch target does not depend on state; it is only meaningful with npc_sel.
    assign w_offset    = {{14{i_d_imm16[15]}}, i_d_imm16, 2'b00};
    assign o_br_target = i_d_pc + 32'd4 + w_offset;

    always_comb begin
        w_cond = 1'b0;
        case (i_br_type)
            3'd1:    w_cond = i_cmp_is0;
            3'd2:    w_cond = ~i_cmp_is0;
            3'd3:    w_cond = i_cmp_e0 | i_cmp_l0;
            3'd4:    w_cond = i_cmp_g0;
            3'd5:    w_cond = i_cmp_l0;
            3'd6:    w_cond = ~i_cmp_l0;
            3'd7:    w_cond = i_cmp_new;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_stall         = 1'b0;
        w_npc_sel       = 1'b0;
        w_resolve       = 1'b0;
        w_taken         = 1'b0;
        w_err_set       = 1'b0;
        case (r_state)
            S_NULL: begin
                // Delay slot of a not-taken likely branch: D content is ignored.
                if (!i_ext_stall) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                if (w_is_br) begin
                    if (!i_opnd_ready) begin
                        // br_stall is reported even while frozen externally.
                        w_stall = 1'b1;
                        if (!i_ext_stall) begin
                            w_next_state    = S_WAIT;
                            w_wait_cnt_next = (r_wait_cnt == WC_LIM) ? r_wait_cnt
                                                                     : r_wait_cnt + 1'b1;
                            w_err_set       = (w_wait_cnt_next == WC_LIM);
                        end
                    end else if (!i_ext_stall) begin
                        w_npc_sel       = w_cond;
                        w_resolve       = 1'b1;
                        w_taken         = w_cond;
                        w_wait_cnt_next = '0;
                        w_next_state    = (i_br_likely && !w_cond) ? S_NULL : S_IDLE;
                    end
                end else if (!i_ext_stall) begin
                    // Branch dropped (e.g. killed by a flush): abandon the wait.
                    w_next_state    = S_IDLE;
                    w_wait_cnt_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_flush_ds  <= 1'b0;
            r_wait_err  <= 1'b0;
            r_cnt_br    <= '0;
            r_cnt_taken <= '0;
            r_cnt_stall <= '0;
        end else if (!i_ext_stall) begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            r_flush_ds <= (w_next_state == S_NULL);
            if (w_err_set) begin
                r_wait_err <= 1'b1;
            end
            if (w_resolve) begin
                r_cnt_br <= r_cnt_br + 1'b1;
            end
            if (w_taken) begin
                r_cnt_taken <= r_cnt_taken + 1'b1;
            end
            if (w_stall) begin
                r_cnt_stall <= r_cnt_stall + 1'b1;
            end
        end
    end

    assign o_br_stall  = w_stall;
    assign o_npc_sel   = w_npc_sel;
    assign o_flush_ds  = r_flush_ds;
    assign o_wait_err  = r_wait_err;
    assign o_cnt_br    = r_cnt_br;
    assign o_cnt_taken = r_cnt_taken;
    assign o_cnt_stall = r_cnt_stall;

endmodule
